// File: rtl/serial_pkg.sv
// -----------------------------------------------------------------------------
// serial_pkg
//   Frame definitions shared by both ends of the serial link (transmitter and
//   receiver). Keeping them in one place means the two ends cannot disagree on
//   state encoding, data width, idle level or parity rule.
//
//   Contents:
//     DATA_BITS      - data bits per frame (sent LSB first)
//     LINE_IDLE      - level of the line between frames (and for stop bits)
//     START_LEVEL    - level of the start bit
//     serial_state_t - 3-bit frame state encoding
//     parity_bit()   - parity over one data byte, even or odd
// -----------------------------------------------------------------------------
package serial_pkg;

  localparam int   DATA_BITS   = 8;
  localparam logic LINE_IDLE   = 1'b1;
  localparam logic START_LEVEL = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } serial_state_t;

  // Even parity makes the total count of ones (data + parity) even, so the
  // parity bit is simply the XOR of the data. Odd parity is its inverse.
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] data,
                                      input logic                 odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// -----------------------------------------------------------------------------
// baud_tick_gen
//   Bit-period timer. Counts 0 .. CLKS_PER_BIT-1 and pulses oTick for one
//   cycle while the count sits at its terminal value; the count then wraps to
//   0, so consecutive bits are exactly CLKS_PER_BIT cycles apart.
//
//   Ports:
//     iClk    - clock, rising edge
//     iRst_n  - asynchronous active-low reset (count -> 0)
//     iClear  - synchronous clear; holds the count at 0 and masks oTick
//     oTick   - one-cycle pulse on the terminal count
// -----------------------------------------------------------------------------
module baud_tick_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic iClk,
  input  logic iRst_n,
  input  logic iClear,
  output logic oTick
);

  localparam int            CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      cnt <= '0;
    end else if (iClear || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign oTick = !iClear && (cnt == LAST);

endmodule

// File: rtl/serial_transmitter.sv
// -----------------------------------------------------------------------------
// serial_transmitter
//   Transmit end of the serial link. Accepts a byte over a valid/ready
//   handshake and sends it as: start bit (0), 8 data bits LSB first, optional
//   parity bit, STOP_BITS stop bits (1). The line idles high.
//
//   Handshake: a byte is transferred on the rising edge where iValid and
//   oReady are both 1. oReady is high in IDLE and also during the final cycle
//   of the last stop bit, so a waiting byte starts its frame with no idle gap.
//   iValid without oReady is ignored (no queuing) and iData is only sampled on
//   the transfer edge.
//
//   Parameters:
//     CLKS_PER_BIT - clock cycles per serial bit (>= 2)
//     PARITY_EN    - 1 inserts a parity bit after the data bits
//     PARITY_ODD   - 0 even parity, 1 odd parity
//     STOP_BITS    - 1 or 2 stop bits
//
//   Ports:
//     iClk    - clock, rising edge
//     iRst_n  - asynchronous active-low reset; aborts any frame in flight
//     iValid  - iData holds a byte to send
//     iData   - byte to send
//     oReady  - a byte offered this cycle will be accepted
//     oTx     - serial line, straight from a flop
//     oBusy   - a frame is in progress
//     oDone   - one-cycle pulse in the final cycle of the last stop bit
//     oState  - current frame state (debug)
// -----------------------------------------------------------------------------
module serial_transmitter
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 iClk,
  input  logic                 iRst_n,
  input  logic                 iValid,
  input  logic [DATA_BITS-1:0] iData,
  output logic                 oReady,
  output logic                 oTx,
  output logic                 oBusy,
  output logic                 oDone,
  output logic [2:0]           oState
);

  localparam logic [2:0] LAST_DATA_IDX = 3'(DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP_IDX = 3'(STOP_BITS - 1);
  localparam logic       ODD_SEL       = (PARITY_ODD != 0);

  serial_state_t        state;
  logic [DATA_BITS-1:0] shift;
  logic [2:0]           bit_idx;   // data bit index, reused to count stop bits
  logic                 par;
  logic                 tick;
  logic                 last_stop;
  logic                 accept;

  // The timer is held at zero while idle so the start bit gets a full period.
  // Every state change happens on a tick, when the counter wraps to zero on
  // its own, so each state begins with a fresh count and no drift builds up.
  baud_tick_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .iClk   (iClk),
    .iRst_n (iRst_n),
    .iClear (state == ST_IDLE),
    .oTick  (tick)
  );

  // Final cycle of the last stop bit. Decoded from flops only, so oDone and
  // oReady are clean; it lets the next byte load on the same edge that would
  // otherwise return to IDLE.
  assign last_stop = (state == ST_STOP) && tick && (bit_idx == LAST_STOP_IDX);
  assign accept    = iValid && oReady;

  assign oReady = (state == ST_IDLE) || last_stop;
  assign oDone  = last_stop;
  assign oBusy  = (state != ST_IDLE);
  assign oState = state;

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state   <= ST_IDLE;
      oTx     <= LINE_IDLE;
      shift   <= '0;
      bit_idx <= '0;
      par     <= 1'b0;
    end else if (accept) begin
      // Capture the byte and its parity now; iData may change freely after.
      state   <= ST_START;
      oTx     <= START_LEVEL;
      shift   <= iData;
      bit_idx <= '0;
      par     <= parity_bit(iData, ODD_SEL);
    end else begin
      case (state)
        ST_IDLE: begin
          oTx <= LINE_IDLE;
        end

        ST_START: begin
          if (tick) begin
            state <= ST_DATA;
            oTx   <= shift[0];
          end
        end

        ST_DATA: begin
          if (tick) begin
            shift <= shift >> 1;
            if (bit_idx == LAST_DATA_IDX) begin
              bit_idx <= '0;
              if (PARITY_EN != 0) begin
                state <= ST_PARITY;
                oTx   <= par;
              end else begin
                state <= ST_STOP;
                oTx   <= LINE_IDLE;
              end
            end else begin
              bit_idx <= bit_idx + 3'd1;
              // shift[1] is the bit that becomes shift[0] on this edge.
              oTx     <= shift[1];
            end
          end
        end

        ST_PARITY: begin
          if (tick) begin
            state   <= ST_STOP;
            oTx     <= LINE_IDLE;
            bit_idx <= '0;
          end
        end

        ST_STOP: begin
          if (tick) begin
            if (bit_idx == LAST_STOP_IDX) begin
              state   <= ST_IDLE;
              oTx     <= LINE_IDLE;
              bit_idx <= '0;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end

        default: begin
          state <= ST_IDLE;
          oTx   <= LINE_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_transmitter.sv
// -----------------------------------------------------------------------------
// tb_serial_transmitter
//   Three transmitter instances with CLKS_PER_BIT=4:
//     0: even parity, 1 stop bit
//     1: odd parity, 2 stop bits
//     2: no parity, 1 stop bit
//   One instance is selected at a time. The driver pushes the expected frame
//   into exp_q when it offers a byte; the monitor pops a frame when the line
//   starts one and checks every cycle of it (line level, busy, ready, done),
//   recovers the byte by mid-bit sampling, and checks the idle line between
//   frames.
// -----------------------------------------------------------------------------
module tb_serial_transmitter;
  import serial_pkg::*;

  localparam int C = 4;

  typedef struct packed {
    logic [3:0]  nbits;
    logic [7:0]  data;
    logic [15:0] bits;   // bits[0] = start bit, sent first
  } frame_t;

  logic       clk;
  logic       rst_n;
  logic [2:0] valid_v;
  logic [7:0] data;
  logic [2:0] ready_v, tx_v, busy_v, done_v;
  logic [2:0] st0, st1, st2;
  int         sel;

  frame_t     exp_q[$];
  int         checks;
  int         failures;

  logic       in_frame;
  logic       stray;
  frame_t     cur;
  int         cyc;
  logic [7:0] rx;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- DUTs ----------------
  serial_transmitter #(.CLKS_PER_BIT(C), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_even1 (
    .iClk(clk), .iRst_n(rst_n), .iValid(valid_v[0]), .iData(data),
    .oReady(ready_v[0]), .oTx(tx_v[0]), .oBusy(busy_v[0]), .oDone(done_v[0]), .oState(st0)
  );

  serial_transmitter #(.CLKS_PER_BIT(C), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u_odd2 (
    .iClk(clk), .iRst_n(rst_n), .iValid(valid_v[1]), .iData(data),
    .oReady(ready_v[1]), .oTx(tx_v[1]), .oBusy(busy_v[1]), .oDone(done_v[1]), .oState(st1)
  );

  serial_transmitter #(.CLKS_PER_BIT(C), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_nopar (
    .iClk(clk), .iRst_n(rst_n), .iValid(valid_v[2]), .iData(data),
    .oReady(ready_v[2]), .oTx(tx_v[2]), .oBusy(busy_v[2]), .oDone(done_v[2]), .oState(st2)
  );

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic frame_t fr(input logic [7:0] d, input logic [15:0] b, input int n);
    frame_t f;
    f.data  = d;
    f.bits  = b;
    f.nbits = 4'(n);
    return f;
  endfunction

  // Reference frame builder used for random bytes.
  function automatic frame_t mk(input logic [7:0] d, input int pen, input int odd, input int stops);
    frame_t f;
    int     n;
    f.data    = d;
    f.bits    = '1;
    f.bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) f.bits[1+i] = d[i];
    n = 9;
    if (pen != 0) begin
      f.bits[9] = (^d) ^ (odd != 0);
      n = 10;
    end
    f.nbits = 4'(n + stops);
    return f;
  endfunction

  // ---------------- driver ----------------
  task automatic send(input frame_t f, input bit hold);
    int t;
    @(negedge clk);
    data         = f.data;
    valid_v[sel] = 1'b1;
    t = 0;
    while (ready_v[sel] !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (ready_v[sel] !== 1'b1) begin
      chk("accept_timeout", {31'd0, ready_v[sel]}, 32'd1);
      valid_v[sel] = 1'b0;
    end else begin
      exp_q.push_back(f);
      @(posedge clk);
      #1;
      if (!hold) valid_v[sel] = 1'b0;
      @(negedge clk);
      chk("start_latency_tx",   {31'd0, tx_v[sel]},   32'd0);
      chk("start_latency_busy", {31'd0, busy_v[sel]}, 32'd1);
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((busy_v[sel] !== 1'b0 || in_frame || exp_q.size() != 0) && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) chk("idle_timeout", {31'd0, busy_v[sel]}, 32'd0);
    @(negedge clk);
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    in_frame = 1'b0;
    stray    = 1'b0;
    cyc      = 0;
    rx       = '0;
    cur      = '0;
  end

  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      in_frame = 1'b0;
      stray    = 1'b0;
    end else begin
      if (!in_frame && !stray && busy_v[sel] === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_frame", exp_q.size(), 32'd1);
          stray = 1'b1;
        end else begin
          cur      = exp_q.pop_front();
          in_frame = 1'b1;
          cyc      = 0;
          rx       = '0;
        end
      end
      if (stray && busy_v[sel] === 1'b0) stray = 1'b0;

      if (in_frame) begin
        int  bi;
        bit  last;
        bi   = cyc / C;
        last = (cyc == int'(cur.nbits) * C - 1);
        chk("frame_tx",    {31'd0, tx_v[sel]},    {31'd0, cur.bits[bi]});
        chk("frame_busy",  {31'd0, busy_v[sel]},  32'd1);
        chk("frame_done",  {31'd0, done_v[sel]},  {31'd0, last});
        chk("frame_ready", {31'd0, ready_v[sel]}, {31'd0, last});
        if ((cyc % C) == C / 2 && bi >= 1 && bi <= 8) rx[bi-1] = tx_v[sel];
        if (last) begin
          chk("rx_byte", {24'd0, rx}, {24'd0, cur.data});
          in_frame = 1'b0;
        end
        cyc++;
      end else if (!stray) begin
        chk("idle_tx",    {31'd0, tx_v[sel]},    32'd1);
        chk("idle_done",  {31'd0, done_v[sel]},  32'd0);
        chk("idle_ready", {31'd0, ready_v[sel]}, 32'd1);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bit         hold;
    logic [7:0] b;
    checks   = 0;
    failures = 0;
    sel      = 0;
    valid_v  = '0;
    data     = '0;
    rst_n    = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_tx",    {29'd0, tx_v},    32'h7);
    chk("rst_ready", {29'd0, ready_v}, 32'h7);
    chk("rst_busy",  {29'd0, busy_v},  32'h0);
    chk("rst_done",  {29'd0, done_v},  32'h0);
    chk("rst_state0", {29'd0, st0}, {29'd0, ST_IDLE});
    chk("rst_state1", {29'd0, st1}, {29'd0, ST_IDLE});
    chk("rst_state2", {29'd0, st2}, {29'd0, ST_IDLE});
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Even parity, 1 stop: 0xA5 -> 0,1,0,1,0,0,1,0,1,0,1 (44 cycles)
    sel = 0;
    send(fr(8'hA5, {5'h1F, 1'b1, 1'b0, 8'hA5, 1'b0}, 11), 1'b0);
    wait_idle();
    // Even parity of 0x01 -> 1
    send(fr(8'h01, {5'h1F, 1'b1, 1'b1, 8'h01, 1'b0}, 11), 1'b0);
    wait_idle();

    // Odd parity, 2 stop bits: 0x01 -> parity 0
    sel = 1;
    send(fr(8'h01, {4'hF, 1'b1, 1'b1, 1'b0, 8'h01, 1'b0}, 12), 1'b0);
    wait_idle();
    // Back-to-back with iValid held: 0x3C then 0xC3 (odd parity -> 1 for both)
    send(fr(8'h3C, {4'hF, 1'b1, 1'b1, 1'b1, 8'h3C, 1'b0}, 12), 1'b1);
    send(fr(8'hC3, {4'hF, 1'b1, 1'b1, 1'b1, 8'hC3, 1'b0}, 12), 1'b0);
    wait_idle();

    // No parity: 10-bit, 40-cycle frames
    sel = 2;
    send(fr(8'h01, {6'h3F, 1'b1, 8'h01, 1'b0}, 10), 1'b0);
    wait_idle();
    send(fr(8'hA5, {6'h3F, 1'b1, 8'hA5, 1'b0}, 10), 1'b0);
    wait_idle();

    // iValid pulsed with 0xFF mid-frame of 0x00, then iData toggling
    sel = 0;
    send(fr(8'h00, {5'h1F, 1'b1, 1'b0, 8'h00, 1'b0}, 11), 1'b0);
    repeat (8) @(negedge clk);
    data       = 8'hFF;
    valid_v[0] = 1'b1;
    @(negedge clk);
    valid_v[0] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      data = 8'($urandom_range(0, 255));
    end
    wait_idle();

    // Reset during data bit 3 of 0x33, then a clean 0x5A frame
    send(fr(8'h33, {5'h1F, 1'b1, 1'b0, 8'h33, 1'b0}, 11), 1'b0);
    repeat (17) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_tx",    {31'd0, tx_v[0]},    32'd1);
    chk("abort_busy",  {31'd0, busy_v[0]},  32'd0);
    chk("abort_ready", {31'd0, ready_v[0]}, 32'd1);
    chk("abort_state", {29'd0, st0}, {29'd0, ST_IDLE});
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(fr(8'h5A, {5'h1F, 1'b1, 1'b0, 8'h5A, 1'b0}, 11), 1'b0);
    wait_idle();

    // Random bytes with random back-to-back / idle gaps
    for (int i = 0; i < 200; i++) begin
      b    = 8'($urandom_range(0, 255));
      hold = ($urandom_range(0, 2) == 0);
      send(mk(b, 1, 0, 1), hold);
      if (!hold && $urandom_range(0, 1) == 1) begin
        wait_idle();
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end
    valid_v = '0;
    wait_idle();

    chk("leftover_frames", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
